// File: rtl/data_sram_responder_pkg.sv
// -----------------------------------------------------------------------------
// data_sram_responder_pkg
// Shared constants for the data-SRAM responder: default device-window base,
// device register offsets (addr[15:0]), the TIMER_CMP reset value and a
// byte-lane merge helper used by both the RAM path and the RW registers.
// -----------------------------------------------------------------------------
package data_sram_responder_pkg;

    localparam logic [31:0] CONFREG_BASE_DEF = 32'hBFAF_0000;
    localparam logic [31:0] TIMER_CMP_RST    = 32'hFFFF_FFFF;

    localparam logic [15:0] OFF_LED        = 16'hF000;
    localparam logic [15:0] OFF_SWITCH     = 16'hF010;
    localparam logic [15:0] OFF_NUM        = 16'hF020;
    localparam logic [15:0] OFF_TIMER      = 16'hE000;
    localparam logic [15:0] OFF_TIMER_CMP  = 16'hE004;
    localparam logic [15:0] OFF_TIMER_STAT = 16'hE008;

    // Replace only the byte lanes whose strobe is set.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  we);
        logic [31:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++) begin
            if (we[b]) res[8*b +: 8] = new_v[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/data_sram_responder_sram_bank.sv
// -----------------------------------------------------------------------------
// data_sram_responder_sram_bank
// Synchronous single-port-per-direction RAM, 2^AW 32-bit words, four byte
// write enables, one-cycle registered read. Contents are never reset.
// Ports:
//   clk      - clock
//   i_rd_en  - capture mem[i_addr] into o_rdata at the next edge
//   i_we     - byte write strobes (4'b0000 = no write)
//   i_addr   - word index
//   i_wdata  - lane-aligned write data
//   o_rdata  - registered read data (changes only after a read)
// -----------------------------------------------------------------------------
module data_sram_responder_sram_bank #(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          i_rd_en,
    input  logic [3:0]    i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [2**AW];
    logic [31:0] r_rdata;

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (i_we[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
        if (i_rd_en) r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/data_sram_responder.sv
// -----------------------------------------------------------------------------
// data_sram_responder
// Responds to a simple SRAM-style data bus: one request per cycle, one-cycle
// read latency, byte-lane writes. Addresses inside the CONFREG_BASE 64 KiB
// window hit device registers (LED, SWITCH, NUM, TIMER, TIMER_CMP,
// TIMER_STAT); everything else goes to the local RAM bank.
// Ports:
//   clk, resetn              - clock, asynchronous active-low reset
//   data_sram_en/we/addr/wdata - request (we==0 means read)
//   data_sram_rdata          - read data, held until the next read completes
//   switch                   - asynchronous board switches (synchronised)
//   led, num_data            - LED and seven-segment registers
//   timer_match              - level copy of TIMER_STAT[0]
// -----------------------------------------------------------------------------
module data_sram_responder
    import data_sram_responder_pkg::*;
#(
    parameter int          RAM_AW       = 12,
    parameter logic [31:0] CONFREG_BASE = CONFREG_BASE_DEF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_we,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    input  logic [7:0]  switch,
    output logic [15:0] led,
    output logic [31:0] num_data,
    output logic        timer_match
);

    logic        w_is_dev;
    logic [15:0] w_off;
    logic        w_rd;
    logic        w_wr;
    logic [31:0] w_dev_rdata;
    logic [31:0] w_ram_rdata;
    logic [31:0] w_rdata_mux;
    logic [31:0] w_led_merged;

    logic [15:0] r_led;
    logic [31:0] r_num;
    logic [31:0] r_timer;
    logic [31:0] r_timer_cmp;
    logic        r_timer_stat;
    logic [7:0]  r_sw_s1;
    logic [7:0]  r_sw_s2;
    logic        r_rd_done;
    logic        r_sel_dev;
    logic [31:0] r_dev_q;
    logic [31:0] r_rdata_hold;

    assign w_is_dev = (data_sram_addr[31:16] == CONFREG_BASE[31:16]);
    assign w_off    = data_sram_addr[15:0];
    assign w_rd     = data_sram_en && (data_sram_we == 4'b0000);
    assign w_wr     = data_sram_en && (data_sram_we != 4'b0000);

    data_sram_responder_sram_bank #(
        .AW (RAM_AW)
    ) sram_bank (
        .clk     (clk),
        .i_rd_en (w_rd && !w_is_dev),
        .i_we    ((w_wr && !w_is_dev) ? data_sram_we : 4'b0000),
        .i_addr  (data_sram_addr[RAM_AW+1:2]),
        .i_wdata (data_sram_wdata),
        .o_rdata (w_ram_rdata)
    );

    always_comb begin
        w_dev_rdata = 32'h0;
        case (w_off)
            OFF_LED:        w_dev_rdata = {16'h0, r_led};
            OFF_SWITCH:     w_dev_rdata = {24'h0, r_sw_s2};
            OFF_NUM:        w_dev_rdata = r_num;
            OFF_TIMER:      w_dev_rdata = r_timer;
            OFF_TIMER_CMP:  w_dev_rdata = r_timer_cmp;
            OFF_TIMER_STAT: w_dev_rdata = {31'h0, r_timer_stat};
            default:        w_dev_rdata = 32'h0;
        endcase
    end

    assign w_led_merged = byte_merge({16'h0, r_led}, data_sram_wdata, data_sram_we);

    // Device registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_led        <= 16'h0;
            r_num        <= 32'h0;
            r_timer      <= 32'h0;
            r_timer_cmp  <= TIMER_CMP_RST;
            r_timer_stat <= 1'b0;
            r_sw_s1      <= 8'h0;
            r_sw_s2      <= 8'h0;
        end else begin
            r_sw_s1 <= switch;
            r_sw_s2 <= r_sw_s1;

            if (w_wr && w_is_dev && w_off == OFF_LED)
                r_led <= w_led_merged[15:0];
            if (w_wr && w_is_dev && w_off == OFF_NUM)
                r_num <= byte_merge(r_num, data_sram_wdata, data_sram_we);
            if (w_wr && w_is_dev && w_off == OFF_TIMER_CMP)
                r_timer_cmp <= byte_merge(r_timer_cmp, data_sram_wdata, data_sram_we);

            // A software write to TIMER takes priority over the free-running count.
            if (w_wr && w_is_dev && w_off == OFF_TIMER)
                r_timer <= byte_merge(r_timer, data_sram_wdata, data_sram_we);
            else
                r_timer <= r_timer + 32'd1;

            // Set has priority over the write-one-to-clear.
            if (r_timer == r_timer_cmp)
                r_timer_stat <= 1'b1;
            else if (w_wr && w_is_dev && w_off == OFF_TIMER_STAT &&
                     data_sram_we[0] && data_sram_wdata[0])
                r_timer_stat <= 1'b0;
        end
    end

    // Read pipeline: remember the source of the read, then mux in the next cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rd_done    <= 1'b0;
            r_sel_dev    <= 1'b0;
            r_dev_q      <= 32'h0;
            r_rdata_hold <= 32'h0;
        end else begin
            r_rd_done <= w_rd;
            if (w_rd) begin
                r_sel_dev <= w_is_dev;
                r_dev_q   <= w_dev_rdata;
            end
            if (r_rd_done) r_rdata_hold <= w_rdata_mux;
        end
    end

    assign w_rdata_mux = r_sel_dev ? r_dev_q : w_ram_rdata;

    // The RAM output register is never reset, so it is only exposed in the
    // cycle right after a read; otherwise the (resettable) hold copy is shown.
    assign data_sram_rdata = r_rd_done ? w_rdata_mux : r_rdata_hold;

    assign led         = r_led;
    assign num_data    = r_num;
    assign timer_match = r_timer_stat;

endmodule
